sos_cascade_ctrl: RTL and testbench

Sequencer that runs a cascade of NUM_STAGES filter_sos biquad sections in series on one input sample. It triggers each section in turn and waits for that section's two-cycle filter_done window. It captures each section's output and feeds it to the next section. It sits between the ADC sample source and the downstream conditioning chain, and adds a per-stage bypass, overrun detection and a completion watchdog.

---
 rtl/sos_ctrl_pkg.sv | 27 ++
 rtl/sos_watchdog.sv | 27 ++
 rtl/sos_cascade_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_sos_cascade_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sos_ctrl_pkg.sv
// Shared state encoding, section handshake timing and helpers for the
// filter_sos cascade sequencer.
package sos_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEL  = 3'd1,
    TRIG = 3'd2,
    WAIT = 3'd3,
    CAPT = 3'd4,
    OUT  = 3'd5
  } ctrl_state_t;

  // filter_sos handshake: done rises DONE_DELAY cycles after trig and stays DONE_LEN cycles
  localparam int DONE_DELAY = 2;
  localparam int DONE_LEN   = 2;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/sos_watchdog.sv
// Per-stage completion watchdog: counts enabled cycles since the last clear
// and flags the cycle in which the TIMEOUT-th enabled cycle occurs.
module sos_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expire = enable && (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/sos_cascade_ctrl.sv
// Sequencer running one sample through NUM_STAGES filter_sos sections in series,
// with per-stage bypass, overrun detection and a completion watchdog.
module sos_cascade_ctrl #(
  parameter int NUM_STAGES = 4,
  parameter int DATA_SIZE  = 24,
  parameter int TIMEOUT    = 15
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_SIZE-1:0]            in_data,
  input  logic [NUM_STAGES-1:0]           bypass_mask,
  output logic [NUM_STAGES-1:0]           stage_trig,
  output logic [DATA_SIZE-1:0]            stage_din,
  input  logic [NUM_STAGES-1:0]           stage_done,
  input  logic [NUM_STAGES*DATA_SIZE-1:0] stage_dout,
  output logic                            out_valid,
  output logic [DATA_SIZE-1:0]            out_data,
  output logic                            overrun,
  output logic                            timeout_err,
  input  logic                            err_clr
);
  import sos_ctrl_pkg::*;

  localparam int IDX_W = clog2(NUM_STAGES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES);

  ctrl_state_t state, next_state;

  logic [DATA_SIZE-1:0]  work_reg;
  logic [NUM_STAGES-1:0] mask;
  logic [IDX_W-1:0]      idx;

  logic [NUM_STAGES-1:0] idx_onehot;
  logic [DATA_SIZE-1:0]  sel_dout;
  logic                  mask_sel;
  logic                  done_sel;
  logic                  at_last;

  logic accept;
  logic skip;
  logic capture;
  logic out_load;
  logic time_fail;
  logic wd_clear;
  logic wd_enable;
  logic wd_expire;

  sos_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  // Decode idx once; done/dout of stages other than the selected one never reach the FSM
  always_comb begin
    idx_onehot = '0;
    sel_dout   = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (idx == IDX_W'(k)) begin
        idx_onehot[k] = 1'b1;
        sel_dout      = stage_dout[k*DATA_SIZE +: DATA_SIZE];
      end
    end
    mask_sel = |(mask & idx_onehot);
    done_sel = |(stage_done & idx_onehot);
    at_last  = (idx == LAST_IDX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    stage_trig = '0;
    accept     = 1'b0;
    skip       = 1'b0;
    capture    = 1'b0;
    out_load   = 1'b0;
    time_fail  = 1'b0;
    wd_clear   = 1'b0;
    wd_enable  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          next_state = SEL;
        end
      end
      SEL: begin
        if (at_last) begin
          // Result is registered on entry to OUT so out_valid coincides with the OUT cycle
          out_load   = 1'b1;
          next_state = OUT;
        end else if (mask_sel) begin
          skip = 1'b1;
        end else begin
          next_state = TRIG;
        end
      end
      TRIG: begin
        stage_trig = idx_onehot;
        wd_clear   = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        if (done_sel) begin
          next_state = CAPT;
        end else begin
          wd_enable = 1'b1;
          if (wd_expire) begin
            time_fail  = 1'b1;
            next_state = IDLE;
          end
        end
      end
      CAPT: begin
        capture    = 1'b1;
        next_state = SEL;
      end
      OUT: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      work_reg <= '0;
      mask     <= '0;
      idx      <= '0;
    end else begin
      if (accept) begin
        work_reg <= in_data;
        mask     <= bypass_mask;
        idx      <= '0;
      end else if (capture) begin
        work_reg <= sel_dout;
        idx      <= idx + 1'b1;
      end else if (skip) begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign stage_din = work_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= out_load;
      if (out_load) begin
        out_data <= work_reg;
      end
    end
  end

  // Sticky flags: a set condition in the same cycle as err_clr wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (in_valid && (state != IDLE)) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
      if (time_fail) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sos_cascade_ctrl.sv
// Self-checking bench for sos_cascade_ctrl: behavioural filter_sos section models
// and a cascade reference model derived from the stage-count latency rule.
module tb_sos_cascade_ctrl;
  import sos_ctrl_pkg::*;

  localparam int NUM_STAGES = 4;
  localparam int DATA_SIZE  = 24;
  localparam int TIMEOUT    = 15;
  localparam int DW         = DATA_SIZE;
  localparam int BUSY_LAST  = DONE_DELAY + DONE_LEN - 1;
  localparam logic [DW-1:0] GARBAGE = 24'hA5C3E1;

  logic                       clk = 1'b0;
  logic                       reset_n = 1'b0;
  logic                       in_valid = 1'b0;
  logic                       in_ready;
  logic [DW-1:0]              in_data = '0;
  logic [NUM_STAGES-1:0]      bypass_mask = '0;
  logic [NUM_STAGES-1:0]      stage_trig;
  logic [DW-1:0]              stage_din;
  logic [NUM_STAGES-1:0]      stage_done;
  logic [NUM_STAGES*DW-1:0]   stage_dout;
  logic                       out_valid;
  logic [DW-1:0]              out_data;
  logic                       overrun;
  logic                       timeout_err;
  logic                       err_clr = 1'b0;

  sos_cascade_ctrl #(
    .NUM_STAGES(NUM_STAGES),
    .DATA_SIZE (DATA_SIZE),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .bypass_mask(bypass_mask),
    .stage_trig (stage_trig),
    .stage_din  (stage_din),
    .stage_done (stage_done),
    .stage_dout (stage_dout),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .overrun    (overrun),
    .timeout_err(timeout_err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Section models: done for DONE_LEN cycles starting DONE_DELAY after trig,
  // data_out = data_in + stage_add[k] only in the last done cycle
  int                    bfm_cnt   [NUM_STAGES];
  logic [DW-1:0]         bfm_din   [NUM_STAGES];
  logic [DW-1:0]         stage_add [NUM_STAGES];
  logic [NUM_STAGES-1:0] hang_mask = '0;
  logic [NUM_STAGES-1:0] noise = '0;
  logic [NUM_STAGES-1:0] bfm_done;
  logic [NUM_STAGES-1:0] bfm_idle;
  bit                    noise_en = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        bfm_cnt[k] <= 0;
        bfm_din[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (stage_trig[k]) begin
          bfm_cnt[k] <= 1;
          bfm_din[k] <= stage_din;
        end else if (bfm_cnt[k] != 0) begin
          bfm_cnt[k] <= (bfm_cnt[k] == BUSY_LAST) ? 0 : bfm_cnt[k] + 1;
        end
      end
    end
  end

  always_comb begin
    bfm_done   = '0;
    bfm_idle   = '0;
    stage_dout = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      bfm_done[k] = !hang_mask[k] && (bfm_cnt[k] >= DONE_DELAY) && (bfm_cnt[k] <= BUSY_LAST);
      bfm_idle[k] = (bfm_cnt[k] == 0);
      stage_dout[k*DW +: DW] = (bfm_cnt[k] == BUSY_LAST) ? (bfm_din[k] + stage_add[k])
                                                          : (GARBAGE ^ DW'(k));
    end
  end

  // Spurious done pulses on idle sections must be ignored by the controller
  always @(negedge clk) noise = noise_en ? NUM_STAGES'($urandom) : '0;

  assign stage_done = bfm_done | (noise & bfm_idle);

  typedef struct packed {
    int                    cycle;
    logic [NUM_STAGES-1:0] trig;
  } trig_ev_t;

  trig_ev_t obs_trig[$];
  trig_ev_t exp_trig[$];

  int            out_cycle;
  int            tmo_cycle;
  int            wait_cycles;
  logic [DW-1:0] out_seen;
  logic          rdy_at_tmo;
  logic          ovr_at2;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: each active stage costs SEL+TRIG+2*WAIT+CAPT, a bypassed stage one SEL,
  // plus the final SEL and the OUT cycle
  task automatic model(input logic [DW-1:0] din, input logic [NUM_STAGES-1:0] m,
                       output logic [DW-1:0] dout, output int lat);
    int nb;
    int na;
    nb = 0;
    na = 0;
    dout = din;
    exp_trig.delete();
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (m[k]) begin
        nb++;
      end else begin
        exp_trig.push_back('{2 + nb + 5 * na, NUM_STAGES'(1) << k});
        dout = dout + stage_add[k];
        na++;
      end
    end
    lat = 2 + nb + 5 * na;
  endtask

  task automatic applyStimulus(input logic [DW-1:0] data, input logic [NUM_STAGES-1:0] m,
                               input bit hold, input int limit);
    obs_trig.delete();
    out_cycle   = -1;
    tmo_cycle   = -1;
    rdy_at_tmo  = 1'b0;
    ovr_at2     = 1'b0;
    wait_cycles = 0;
    out_seen    = '0;
    in_data     = data;
    bypass_mask = m;
    while (!in_ready && wait_cycles < 50) begin
      step();
      wait_cycles++;
    end
    in_valid = 1'b1;
    for (int c = 1; c <= limit; c++) begin
      step();
      if (!hold) in_valid = 1'b0;
      if (stage_trig != '0) obs_trig.push_back('{c, stage_trig});
      if (c == 2) ovr_at2 = overrun;
      if (timeout_err && tmo_cycle < 0) begin
        tmo_cycle  = c;
        rdy_at_tmo = in_ready;
      end
      if (out_valid) begin
        out_cycle = c;
        out_seen  = out_data;
        break;
      end
    end
  endtask

  task automatic compareTrigs(input string tag);
    checkOutput({tag, "_trig_count"}, 64'(obs_trig.size()), 64'(exp_trig.size()));
    for (int i = 0; i < exp_trig.size(); i++) begin
      if (i < obs_trig.size()) begin
        checkOutput($sformatf("%s_trig%0d_cycle", tag, i), 64'(obs_trig[i].cycle), 64'(exp_trig[i].cycle));
        checkOutput($sformatf("%s_trig%0d_onehot", tag, i), 64'(obs_trig[i].trig), 64'(exp_trig[i].trig));
      end
    end
  endtask

  task automatic runAndCheck(input string tag, input logic [DW-1:0] data, input logic [NUM_STAGES-1:0] m);
    logic [DW-1:0] exp_data;
    int            exp_lat;
    model(data, m, exp_data, exp_lat);
    applyStimulus(data, m, 1'b0, 60);
    checkOutput({tag, "_latency"}, 64'(out_cycle), 64'(exp_lat));
    checkOutput({tag, "_out_data"}, 64'(out_seen), 64'(exp_data));
    compareTrigs(tag);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish within the time limit");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    logic [DW-1:0]         exp_data;
    logic [DW-1:0]         d;
    logic [NUM_STAGES-1:0] m;
    int                    exp_lat;
    int                    cnt;

    for (int k = 0; k < NUM_STAGES; k++) stage_add[k] = 24'd1;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_stage_trig", 64'(stage_trig), 64'd0);
    checkOutput("rst_stage_din", 64'(stage_din), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_data", 64'(out_data), 64'd0);
    checkOutput("rst_overrun", 64'(overrun), 64'd0);
    checkOutput("rst_timeout_err", 64'(timeout_err), 64'd0);
    reset_n = 1'b1;
    step();
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

    runAndCheck("all_active", 24'h000010, 4'b0000);
    runAndCheck("mask1010", 24'h7FFFF0, 4'b1010);
    runAndCheck("all_bypass", 24'h800000, 4'b1111);

    // in_valid held high across a whole operation
    d = DW'($urandom);
    model(d, 4'b0000, exp_data, exp_lat);
    applyStimulus(d, 4'b0000, 1'b1, 60);
    checkOutput("hold_overrun_c2", 64'(ovr_at2), 64'd1);
    checkOutput("hold_latency", 64'(out_cycle), 64'(exp_lat));
    checkOutput("hold_out_data", 64'(out_seen), 64'(exp_data));
    compareTrigs("hold");
    d = DW'($urandom);
    model(d, 4'b0000, exp_data, exp_lat);
    applyStimulus(d, 4'b0000, 1'b0, 60);
    checkOutput("hold_next_accept_gap", 64'(wait_cycles), 64'd1);
    checkOutput("hold_next_latency", 64'(out_cycle), 64'(exp_lat));
    checkOutput("hold_next_out_data", 64'(out_seen), 64'(exp_data));

    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checkOutput("errclr_overrun", 64'(overrun), 64'd0);

    // err_clr coinciding with a new violation leaves overrun set
    d = DW'($urandom);
    model(d, 4'b0000, exp_data, exp_lat);
    in_data     = d;
    bypass_mask = 4'b0000;
    in_valid    = 1'b1;
    step();
    err_clr = 1'b1;
    step();
    in_valid = 1'b0;
    err_clr  = 1'b0;
    checkOutput("errclr_set_wins", 64'(overrun), 64'd1);
    cnt = 2;
    while (!out_valid && cnt < 60) begin
      step();
      cnt++;
    end
    checkOutput("errclr_run_latency", 64'(cnt), 64'(exp_lat));
    checkOutput("errclr_run_out_data", 64'(out_data), 64'(exp_data));
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;

    // Stage 1 never answers
    hang_mask = 4'b0010;
    d = DW'($urandom);
    model(d, 4'b0000, exp_data, exp_lat);
    applyStimulus(d, 4'b0000, 1'b0, 40);
    checkOutput("hang_no_out_valid", 64'(out_cycle), 64'(-1));
    checkOutput("hang_timeout_cycle", 64'(tmo_cycle), 64'(exp_trig[1].cycle + TIMEOUT + 1));
    checkOutput("hang_in_ready", 64'(rdy_at_tmo), 64'd1);
    checkOutput("hang_trig_count", 64'(obs_trig.size()), 64'd2);
    hang_mask = '0;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checkOutput("hang_errclr", 64'(timeout_err), 64'd0);
    runAndCheck("after_hang", DW'($urandom), 4'b0000);

    // Reset while waiting on stage 2, with overrun set beforehand
    step();
    in_data     = DW'($urandom);
    bypass_mask = 4'b0000;
    in_valid    = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    for (int c = 3; c <= 13; c++) step();
    checkOutput("prerst_overrun", 64'(overrun), 64'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_stage_trig", 64'(stage_trig), 64'd0);
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_out_data", 64'(out_data), 64'd0);
    checkOutput("midrst_overrun", 64'(overrun), 64'd0);
    checkOutput("midrst_timeout_err", 64'(timeout_err), 64'd0);
    step();
    step();
    reset_n = 1'b1;
    step();
    checkOutput("postrst_in_ready", 64'(in_ready), 64'd1);
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (out_valid) cnt++;
      step();
    end
    checkOutput("postrst_no_out_valid", 64'(cnt), 64'd0);
    runAndCheck("after_reset", DW'($urandom), 4'b0000);

    // Randomized samples, masks and section transfer with idle-section done noise
    noise_en = 1'b1;
    for (int k = 0; k < NUM_STAGES; k++) stage_add[k] = DW'($urandom);
    for (int n = 0; n < 12; n++) begin
      d = DW'($urandom);
      m = NUM_STAGES'($urandom);
      runAndCheck($sformatf("rand%0d", n), d, m);
    end
    noise_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
